// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//
// Read-side master for the team FIFO. Words are popped from the FIFO's
// show-ahead port and re-emitted on an AXI-Stream master, framed into
// fixed-length packets with m_tlast on the final beat of each packet.
//
// A 2-entry output buffer decouples the FIFO pop from m_tready: the pop
// request only looks at buffer occupancy, never at m_tready.
//
// Parameters:
//   WIDTH   - data word width (must match the FIFO)
//   PKT_LEN - beats per packet (>= 1)
//   CNT_W   - width of the word/packet status counters
//
// Ports:
//   clk          - system clock, all state on posedge
//   reset        - asynchronous, active-low reset
//   enable       - level, 1 = pull words from the FIFO
//   fifo_empty   - FIFO empty flag
//   fifo_data    - FIFO head word (valid while fifo_empty = 0)
//   fifo_r_ready - pop request to the FIFO
//   m_tvalid     - stream valid
//   m_tdata      - stream data
//   m_tlast      - last beat of packet
//   m_tready     - stream ready
//   word_cnt     - beats accepted downstream (wraps)
//   pkt_cnt      - packets completed downstream (wraps)
//   busy         - 1 when the FSM is not IDLE

module fifo_stream_reader #(
  parameter int WIDTH   = 32,
  parameter int PKT_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_r_ready,
  output logic             m_tvalid,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             busy
);

  // Beat index needs at least one bit even when every beat is last.
  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             last0;
  logic             last1;
  logic [IDX_W-1:0] beat_idx;
  logic             pop;
  logic             handshake;
  logic             pop_last;

  // The reset term keeps the pop request low the instant reset asserts,
  // even though enable and fifo_empty are free-running inputs.
  assign pop          = reset & enable & ~fifo_empty & (occ != 2'd2);
  assign fifo_r_ready = pop;

  assign m_tvalid  = (occ != 2'd0);
  assign m_tdata   = data0;
  assign m_tlast   = last0;
  assign handshake = m_tvalid & m_tready;
  assign pop_last  = (beat_idx == LAST_IDX);
  assign busy      = (state != IDLE);

  // Occupancy after this edge: a simultaneous pop and handshake cancel.
  always_comb begin
    occ_next = occ;
    case ({pop, handshake})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // Output buffer: entry 0 is the head presented on the stream, entry 1
  // holds the word behind it. A handshake shifts entry 1 forward; a pop
  // lands in the first free slot after any shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data0    <= '0;
      data1    <= '0;
      last0    <= 1'b0;
      last1    <= 1'b0;
      occ      <= 2'd0;
      beat_idx <= '0;
    end else begin
      case ({pop, handshake})
        2'b10: begin
          if (occ == 2'd0) begin
            data0 <= fifo_data;
            last0 <= pop_last;
          end else begin
            data1 <= fifo_data;
            last1 <= pop_last;
          end
        end
        2'b01: begin
          data0 <= data1;
          last0 <= last1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            data0 <= fifo_data;
            last0 <= pop_last;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= fifo_data;
            last1 <= pop_last;
          end
        end
        default: begin
        end
      endcase
      occ <= occ_next;
      // The index survives enable drops so a packet resumes where it left off.
      if (pop) begin
        beat_idx <= pop_last ? '0 : beat_idx + IDX_W'(1);
      end
    end
  end

  // Status counters track beats and packets accepted downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (handshake) begin
      word_cnt <= word_cnt + CNT_W'(1);
      if (m_tlast) begin
        pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DRAIN lets buffered words finish after enable drops; it is decided on
  // the post-edge occupancy so an empty buffer goes straight to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) state_next = RUN;
      end
      RUN: begin
        if (!enable) state_next = (occ_next != 2'd0) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (enable)                state_next = RUN;
        else if (occ_next == 2'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//
// Scoreboard bench for fifo_stream_reader (PKT_LEN = 4). A FIFO model
// feeds the DUT; every loaded word that should reach the stream is pushed
// with its hand-computed last flag into an expected queue, and a monitor
// on the falling edge pops and compares each accepted beat. Inputs change
// 2 time units after the rising edge, the FIFO model updates 1 unit after.

module tb_fifo_stream_reader;

  localparam int WIDTH   = 32;
  localparam int PKT_LEN = 4;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             fifo_r_ready;
  logic             m_tvalid;
  logic [WIDTH-1:0] m_tdata;
  logic             m_tlast;
  logic             m_tready = 1'b0;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] pkt_cnt;
  logic             busy;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t            exp_q[$];
  logic [WIDTH-1:0] fifo_q[$];
  beat_t            exp_beat;
  int               num_compared = 0;
  int               num_mismatched = 0;
  int               pop_count = 0;
  int               cyc = 0;
  int               first_hs_cyc = -1;
  int               last_hs_cyc = -1;
  logic             pend_pop = 1'b0;
  logic             toggle_mode = 1'b0;
  logic             toggle_phase = 1'b0;
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] held_data = '0;
  logic             held_last = 1'b0;

  fifo_stream_reader #(
    .WIDTH  (WIDTH),
    .PKT_LEN(PKT_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_r_ready(fifo_r_ready),
    .m_tvalid    (m_tvalid),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .word_cnt    (word_cnt),
    .pkt_cnt     (pkt_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: applies the pop seen before the edge, then presents the
  // new head. In toggle mode the empty flag is forced on every other cycle.
  always @(posedge clk) begin
    #1;
    if (pend_pop) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_count++;
    end
    toggle_phase = toggle_mode ? ~toggle_phase : 1'b0;
    fifo_empty   = (fifo_q.size() == 0) || toggle_phase;
    fifo_data    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // Monitor: samples mid-cycle, checks pop legality, stall stability and
  // every accepted beat against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    pend_pop = fifo_r_ready && !fifo_empty;
    if (reset && enable && fifo_empty) begin
      num_compared++;
      if (fifo_r_ready !== 1'b0) begin
        num_mismatched++;
        $display("[TB] FAIL pop_while_empty: fifo_r_ready=%b required 0", fifo_r_ready);
      end
    end
    if (reset && stall_prev && m_tvalid) begin
      num_compared++;
      if (m_tdata !== held_data || m_tlast !== held_last) begin
        num_mismatched++;
        $display("[TB] FAIL stall_hold: data=%0d last=%b required data=%0d last=%b",
                 m_tdata, m_tlast, held_data, held_last);
      end
    end
    if (m_tvalid && m_tready) begin
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      num_compared++;
      if (exp_q.size() == 0) begin
        num_mismatched++;
        $display("[TB] FAIL unexpected_beat: data=%0d last=%b required no beat", m_tdata, m_tlast);
      end else begin
        exp_beat = exp_q.pop_front();
        if (m_tdata !== exp_beat.data || m_tlast !== exp_beat.last) begin
          num_mismatched++;
          $display("[TB] FAIL beat: data=%0d last=%b required data=%0d last=%b",
                   m_tdata, m_tlast, exp_beat.data, exp_beat.last);
        end
      end
    end
    stall_prev = reset && m_tvalid && !m_tready;
    held_data  = m_tdata;
    held_last  = m_tlast;
  end

  task automatic applyStimulus(input logic en, input logic rdy);
    @(posedge clk);
    #2;
    enable   = en;
    m_tready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic loadWord(input logic [WIDTH-1:0] d, input logic last, input logic expect_it);
    fifo_q.push_back(d);
    if (expect_it) exp_q.push_back(beat_t'{data: d, last: last});
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic waitPops(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (pop_count < target && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput(name, 32'(pop_count >= target), 32'd1);
  endtask

  task automatic waitDrained(input string name, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !m_tvalid) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput(name, 32'(exp_q.size() == 0 && fifo_q.size() == 0 && !m_tvalid), 32'd1);
  endtask

  logic t2_last [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic t3_last [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int base;
    int n;

    // Reset with enable high and the FIFO empty.
    enable   = 1'b1;
    m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("t1_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("t1_r_ready", 32'(fifo_r_ready), 32'd0);
    checkOutput("t1_word_cnt", 32'(word_cnt), 32'd0);
    checkOutput("t1_pkt_cnt", 32'(pkt_cnt), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd1);

    // Eight preloaded words stream back-to-back, last on 3 and 7.
    m_tready     = 1'b1;
    first_hs_cyc = -1;
    for (int i = 0; i < 8; i++) loadWord(WIDTH'(i), t2_last[i], 1'b1);
    waitDrained("t2_drain", 50);
    checkOutput("t2_consecutive", 32'(last_hs_cyc - first_hs_cyc), 32'd7);
    checkOutput("t2_word_cnt", 32'(word_cnt), 32'd8);
    checkOutput("t2_pkt_cnt", 32'(pkt_cnt), 32'd2);

    // Stalled stream: buffer fills with two words, then pops stop.
    m_tready = 1'b0;
    base     = pop_count;
    for (int i = 0; i < 6; i++) loadWord(WIDTH'(i), t3_last[i], 1'b1);
    repeat (8) begin
      @(posedge clk);
      #2;
    end
    checkOutput("t3_two_pops", 32'(pop_count - base), 32'd2);
    checkOutput("t3_r_ready", 32'(fifo_r_ready), 32'd0);
    checkOutput("t3_tvalid", 32'(m_tvalid), 32'd1);
    checkOutput("t3_tdata_held", m_tdata, 32'd0);
    m_tready = 1'b1;
    waitDrained("t3_drain", 50);
    checkOutput("t3_word_cnt", 32'(word_cnt), 32'd14);
    checkOutput("t3_pkt_cnt", 32'(pkt_cnt), 32'd3);

    // Enable dropped mid-packet after two pops, then resumed.
    doReset();
    m_tready = 1'b1;
    base     = pop_count;
    for (int i = 0; i < 8; i++) loadWord(WIDTH'(10 + i), t2_last[i], 1'b1);
    waitPops("t4_first_pops", base + 2, 50);
    enable = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("t4_busy_falls", 32'(busy), 32'd0);
    repeat (4) begin
      @(posedge clk);
      #2;
    end
    checkOutput("t4_no_pops", 32'(pop_count - base), 32'd2);
    checkOutput("t4_two_drained", 32'(exp_q.size()), 32'd6);
    applyStimulus(1'b1, 1'b1);
    waitDrained("t4_drain", 50);
    checkOutput("t4_word_cnt", 32'(word_cnt), 32'd8);
    checkOutput("t4_pkt_cnt", 32'(pkt_cnt), 32'd2);

    // Reset mid-packet with two words buffered: they are discarded and the
    // packet index restarts, so last lands on 25 and 29.
    m_tready = 1'b0;
    base     = pop_count;
    loadWord(WIDTH'(20), 1'b0, 1'b0);
    loadWord(WIDTH'(21), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) loadWord(WIDTH'(22 + i), t2_last[i], 1'b1);
    waitPops("t5_two_pops", base + 2, 50);
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    checkOutput("t5_pre_tdata", m_tdata, 32'd20);
    reset = 1'b0;
    #1;
    checkOutput("t5_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("t5_r_ready", 32'(fifo_r_ready), 32'd0);
    checkOutput("t5_tlast", 32'(m_tlast), 32'd0);
    checkOutput("t5_tdata", m_tdata, 32'd0);
    checkOutput("t5_word_cnt", 32'(word_cnt), 32'd0);
    checkOutput("t5_pkt_cnt", 32'(pkt_cnt), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    reset    = 1'b1;
    m_tready = 1'b1;
    waitDrained("t5_drain", 50);
    checkOutput("t5_pkt_cnt_after", 32'(pkt_cnt), 32'd2);

    // Flickering empty flag and random ready over 40 words.
    doReset();
    toggle_mode = 1'b1;
    base        = pop_count;
    for (int i = 0; i < 40; i++) loadWord(WIDTH'(100 + i), (i % 4) == 3, 1'b1);
    n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !m_tvalid) && n < 2000) begin
      @(posedge clk);
      #2;
      m_tready = 1'($urandom_range(0, 1));
      n++;
    end
    checkOutput("t6_drain", 32'(exp_q.size() == 0 && fifo_q.size() == 0 && !m_tvalid), 32'd1);
    checkOutput("t6_pops", 32'(pop_count - base), 32'd40);
    checkOutput("t6_word_cnt", 32'(word_cnt), 32'd40);
    checkOutput("t6_pkt_cnt", 32'(pkt_cnt), 32'd10);
    toggle_mode = 1'b0;
    m_tready    = 1'b0;

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
